// File: rtl/param_seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives the request and operands; the slave (the divider) returns the results.
interface param_seq_divider_if #(
    parameter int DW = 8
);
    logic            start;
    logic            signed_mode;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            busy;
    logic            done;
    logic            error;
    logic            overflow;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, error, overflow, quotient, remainder
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, error, overflow, quotient, remainder
    );
endinterface

// File: rtl/param_seq_divider.sv
// Multi-cycle restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient and remainder.
// Signed operation works on magnitudes and applies the signs at the end (truncating division,
// remainder follows the dividend). Divide-by-zero and quotient overflow exit early from CHECK.
module param_seq_divider #(
    parameter int DW        = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    param_seq_divider_if.slave bus
);
    localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ITER,
        FIXUP,
        DONE
    } state_t;

    state_t            state_reg;
    logic [2*DW-1:0]   dvd_reg;
    logic [DW-1:0]     dvs_reg;
    logic              smode_reg;
    logic [DW-1:0]     dvs_mag_reg;
    logic [DW-1:0]     rem_reg;
    logic [DW-1:0]     work_reg;
    logic              qneg_reg;
    logic              rneg_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic              overflow_reg;
    logic [DW-1:0]     quotient_reg;
    logic [DW-1:0]     remainder_reg;

    // Operand magnitudes; only negated when the latched mode is signed and the operand is negative.
    logic              dvd_neg;
    logic              dvs_neg;
    logic [2*DW-1:0]   dvd_mag;
    logic [DW-1:0]     dvs_mag;

    assign dvd_neg = smode_reg & dvd_reg[2*DW-1];
    assign dvs_neg = smode_reg & dvs_reg[DW-1];
    assign dvd_mag = dvd_neg ? -dvd_reg : dvd_reg;
    assign dvs_mag = dvs_neg ? -dvs_reg : dvs_reg;

    // Trial subtract at DW+1 bits: the partial remainder stays below |divisor|, so the
    // difference always lies in (-|divisor|, |divisor|) and its top bit is a true sign.
    logic [DW:0]       shifted;
    logic [DW:0]       trial;

    assign shifted = {rem_reg, work_reg[DW-1]};
    assign trial   = shifted - {1'b0, dvs_mag_reg};

    // Sign application and signed-range check on the final magnitudes.
    logic [DW-1:0]     q_signed;
    logic [DW-1:0]     r_signed;
    logic              sovf;

    assign q_signed = qneg_reg ? -work_reg : work_reg;
    assign r_signed = rneg_reg ? -rem_reg : rem_reg;
    assign sovf     = smode_reg & (qneg_reg ? (work_reg[DW-1] & (|work_reg[DW-2:0]))
                                            : work_reg[DW-1]);

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            smode_reg     <= 1'b0;
            dvs_mag_reg   <= '0;
            rem_reg       <= '0;
            work_reg      <= '0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        dvd_reg      <= bus.dividend;
                        dvs_reg      <= bus.divisor;
                        smode_reg    <= bus.signed_mode & SIGNED_EN;
                        error_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= CHECK;
                    end
                end
                CHECK: begin
                    qneg_reg <= dvd_neg ^ dvs_neg;
                    rneg_reg <= dvd_neg;
                    if (dvs_reg == '0) begin
                        error_reg     <= 1'b1;
                        quotient_reg  <= '1;
                        remainder_reg <= dvd_reg[DW-1:0];
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else if (dvd_mag[2*DW-1:DW] >= dvs_mag) begin
                        overflow_reg  <= 1'b1;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        dvs_mag_reg <= dvs_mag;
                        rem_reg     <= dvd_mag[2*DW-1:DW];
                        work_reg    <= dvd_mag[DW-1:0];
                        cnt_reg     <= '0;
                        state_reg   <= ITER;
                    end
                end
                ITER: begin
                    if (!trial[DW]) begin
                        rem_reg  <= trial[DW-1:0];
                        work_reg <= {work_reg[DW-2:0], 1'b1};
                    end else begin
                        rem_reg  <= shifted[DW-1:0];
                        work_reg <= {work_reg[DW-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DW - 1)) begin
                        state_reg <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (sovf) begin
                        overflow_reg  <= 1'b1;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                    end else begin
                        quotient_reg  <= q_signed;
                        remainder_reg <= r_signed;
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.error     = error_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
endmodule

// File: tb/tb_param_seq_divider.sv
// Directed bench for param_seq_divider (DW=8): one signed-capable instance and one with
// signed support compiled out, driven through the bus interface.
module tb_param_seq_divider;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_seq_divider_if #(.DW(DW)) a_if ();
    param_seq_divider_if #(.DW(DW)) b_if ();

    param_seq_divider #(.DW(DW), .SIGNED_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    param_seq_divider #(.DW(DW), .SIGNED_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on dut_a. Operands are scrambled after acceptance; optionally a second
    // start pulse with other operands is injected mid-iteration.
    task automatic run_a(input logic sm, input logic [15:0] dd, input logic [7:0] dv,
                         input bit disturb, output int lat, output int bcnt);
        @(negedge clk);
        a_if.start       = 1'b1;
        a_if.signed_mode = sm;
        a_if.dividend    = dd;
        a_if.divisor     = dv;
        @(negedge clk);
        a_if.start       = 1'b0;
        a_if.signed_mode = ~sm;
        a_if.dividend    = ~dd;
        a_if.divisor     = dv ^ 8'h5A;
        lat  = 1;
        bcnt = 0;
        while (a_if.done !== 1'b1 && lat < 50) begin
            if (a_if.busy === 1'b1) bcnt++;
            a_if.start = (disturb && lat == 4) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        a_if.start = 1'b0;
        $display("A sm=%0d %h/%h -> q=%h r=%h err=%0d ovf=%0d lat=%0d busy=%0d",
                 sm, dd, dv, a_if.quotient, a_if.remainder, a_if.error, a_if.overflow, lat, bcnt);
    endtask

    task automatic run_b(input logic sm, input logic [15:0] dd, input logic [7:0] dv,
                         output int lat);
        @(negedge clk);
        b_if.start       = 1'b1;
        b_if.signed_mode = sm;
        b_if.dividend    = dd;
        b_if.divisor     = dv;
        @(negedge clk);
        b_if.start = 1'b0;
        lat = 1;
        while (b_if.done !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        $display("B sm=%0d %h/%h -> q=%h r=%h err=%0d ovf=%0d lat=%0d",
                 sm, dd, dv, b_if.quotient, b_if.remainder, b_if.error, b_if.overflow, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        int lat;
        int bcnt;

        reset = 1'b1;
        a_if.start = 1'b0; a_if.signed_mode = 1'b0; a_if.dividend = '0; a_if.divisor = '0;
        b_if.start = 1'b0; b_if.signed_mode = 1'b0; b_if.dividend = '0; b_if.divisor = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_flags", {31'd0, a_if.busy}, 32'd0);
        check("rst_done", {31'd0, a_if.done}, 32'd0);
        check("rst_errovf", {30'd0, a_if.error, a_if.overflow}, 32'd0);
        check("rst_q", {24'd0, a_if.quotient}, 32'd0);
        check("rst_r", {24'd0, a_if.remainder}, 32'd0);
        reset = 1'b0;

        // Unsigned 1000 / 7 = 142 r 6
        run_a(1'b0, 16'h03E8, 8'h07, 1'b0, lat, bcnt);
        check("u_lat", lat, 32'd11);
        check("u_busy", bcnt, 32'd10);
        check("u_busy_at_done", {31'd0, a_if.busy}, 32'd0);
        check("u_q", {24'd0, a_if.quotient}, 32'h8E);
        check("u_r", {24'd0, a_if.remainder}, 32'h06);
        check("u_flags", {30'd0, a_if.error, a_if.overflow}, 32'd0);
        @(negedge clk);
        check("u_done_pulse", {31'd0, a_if.done}, 32'd0);
        check("u_q_held", {24'd0, a_if.quotient}, 32'h8E);

        // Divide by zero
        run_a(1'b0, 16'h04D2, 8'h00, 1'b0, lat, bcnt);
        check("z_lat", lat, 32'd2);
        check("z_busy", bcnt, 32'd1);
        check("z_flags", {30'd0, a_if.error, a_if.overflow}, 32'd2);
        check("z_q", {24'd0, a_if.quotient}, 32'hFF);
        check("z_r", {24'd0, a_if.remainder}, 32'hD2);

        // Unsigned overflow (back-to-back with the previous op)
        run_a(1'b0, 16'h1000, 8'h10, 1'b0, lat, bcnt);
        check("o_lat", lat, 32'd2);
        check("o_flags", {30'd0, a_if.error, a_if.overflow}, 32'd1);
        check("o_q", {24'd0, a_if.quotient}, 32'h00);
        check("o_r", {24'd0, a_if.remainder}, 32'h00);

        // Signed -100 / 7 = -14 r -2
        run_a(1'b1, 16'hFF9C, 8'h07, 1'b0, lat, bcnt);
        check("s_lat", lat, 32'd11);
        check("s_q", {24'd0, a_if.quotient}, 32'hF2);
        check("s_r", {24'd0, a_if.remainder}, 32'hFE);
        check("s_flags", {30'd0, a_if.error, a_if.overflow}, 32'd0);

        // Signed -128 / -1 overflows
        run_a(1'b1, 16'hFF80, 8'hFF, 1'b0, lat, bcnt);
        check("so_lat", lat, 32'd11);
        check("so_flags", {30'd0, a_if.error, a_if.overflow}, 32'd1);
        check("so_q", {24'd0, a_if.quotient}, 32'h00);

        // Signed 800 / -7 = -114 r 2
        run_a(1'b1, 16'h0320, 8'hF9, 1'b0, lat, bcnt);
        check("sn_q", {24'd0, a_if.quotient}, 32'h8E);
        check("sn_r", {24'd0, a_if.remainder}, 32'h02);

        // Same operands on the unsigned-only instance: 800 / 249 = 3 r 53
        run_b(1'b1, 16'h0320, 8'hF9, lat);
        check("b_lat", lat, 32'd11);
        check("b_q", {24'd0, b_if.quotient}, 32'h03);
        check("b_r", {24'd0, b_if.remainder}, 32'h35);
        check("b_flags", {30'd0, b_if.error, b_if.overflow}, 32'd0);

        // Signed -128 / 1 = -128, fits exactly
        run_a(1'b1, 16'hFF80, 8'h01, 1'b0, lat, bcnt);
        check("sm_q", {24'd0, a_if.quotient}, 32'h80);
        check("sm_r", {24'd0, a_if.remainder}, 32'h00);
        check("sm_flags", {30'd0, a_if.error, a_if.overflow}, 32'd0);

        // start pulsed mid-iteration is ignored
        run_a(1'b0, 16'h03E8, 8'h07, 1'b1, lat, bcnt);
        check("ign_lat", lat, 32'd11);
        check("ign_q", {24'd0, a_if.quotient}, 32'h8E);
        check("ign_r", {24'd0, a_if.remainder}, 32'h06);

        // Reset asserted mid-iteration; results from a prior nonzero op must clear at once
        run_a(1'b1, 16'hFF80, 8'h01, 1'b0, lat, bcnt);
        @(negedge clk);
        a_if.start = 1'b1; a_if.signed_mode = 1'b0; a_if.dividend = 16'h03E8; a_if.divisor = 8'h07;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_busy_before", {31'd0, a_if.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mr_busy", {31'd0, a_if.busy}, 32'd0);
        check("mr_q", {24'd0, a_if.quotient}, 32'h00);
        check("mr_r_done", {23'd0, a_if.remainder, a_if.done}, 32'd0);
        $display("A reset mid-iteration: q=%h busy=%0d", a_if.quotient, a_if.busy);
        @(negedge clk);
        reset = 1'b0;

        // New operation after reset: 255 / 16 = 15 r 15
        run_a(1'b0, 16'h00FF, 8'h10, 1'b0, lat, bcnt);
        check("ar_lat", lat, 32'd11);
        check("ar_q", {24'd0, a_if.quotient}, 32'h0F);
        check("ar_r", {24'd0, a_if.remainder}, 32'h0F);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/param_seq_divider.md
Name: param_seq_divider

Overview:
- Parametrised multi-cycle restoring divider; successor to the fixed 16/8 unsigned divider datapath.
- Divides a 2*DW-bit dividend by a DW-bit divisor and returns a DW-bit quotient and a DW-bit remainder.
- Adds a start/busy/done handshake, a run-time signed mode, divide-by-zero detection and quotient-overflow detection.
- Sits between the operand registers and the result checker/output stage of the arithmetic unit.

Parameters:
- DW, 8, divisor/quotient/remainder width; dividend width is 2*DW; legal range 4..32.
- SIGNED_EN, 1, when 0, signed_mode is ignored and treated as 0; signed logic may be removed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- dividend  input  2*DW  dividend; latched with start.
- divisor  input  DW  divisor; latched with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- error  output  1  divide-by-zero flag, valid with done and held.
- overflow  output  1  quotient does not fit in DW bits (signed or unsigned), valid with done and held.
- quotient  output  DW  result quotient, held until the next accepted start.
- remainder  output  DW  result remainder, held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. busy, done, error, overflow, quotient and remainder are all 0.
- FSM states: IDLE -> CHECK -> ITER -> FIXUP -> DONE -> IDLE.
- IDLE:
  - start=1 latches dividend, divisor and signed_mode (forced to 0 when SIGNED_EN=0) and moves to CHECK.
  - Clears error and overflow.
  - quotient and remainder keep their old values until DONE.
- CHECK (busy=1):
  - Form magnitudes: in signed mode, take the absolute value of each operand; otherwise use them as-is.
  - Record quotient sign = sign(dividend) XOR sign(divisor), and remainder sign = sign(dividend).
  - If divisor == 0: set error, quotient = all ones, remainder = dividend[DW-1:0], go to DONE.
  - Else if |dividend|[2*DW-1:DW] >= |divisor|: set overflow, go to DONE.
  - Else go to ITER with the iteration counter at 0.
- ITER (exactly DW cycles, busy=1):
  - Each cycle, shift the partial remainder left by 1, bringing in the next dividend bit.
  - Trial subtract |divisor|. If the result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
  - The counter runs 0..DW-1; at DW-1 go to FIXUP.
- FIXUP:
  - Apply the quotient sign and remainder sign (truncating division; remainder takes the sign of the dividend).
  - Signed overflow: set overflow if the positive quotient magnitude > 2^(DW-1)-1, or the negative quotient magnitude > 2^(DW-1).
  - When overflow is set, quotient and remainder are forced to 0.
- DONE: done=1 for exactly one cycle, busy=0; results and flags are registered; return to IDLE.
- Latency: start accepted at edge N; done is high in the cycle after edge N+DW+2. Total DW+3 cycles. Error and overflow exits happen at CHECK, so done follows 2 cycles after start.
- start while busy: ignored; no effect on the operation in flight.
- Input changes after acceptance: no effect.
- start high in IDLE on the same cycle that DONE returns to IDLE: accepted normally, giving back-to-back operations.
- Overflow and error are mutually exclusive; error has priority.
- All arithmetic is internal at DW+1 bits for the trial subtract; no wrap-around on the quotient outputs except as defined above.

Test Plan (DW=8 unless stated):
- Unsigned: dividend=1000 (0x03E8), divisor=7 -> quotient=0x8E (142), remainder=0x06, error=0, overflow=0. done high exactly 11 cycles after start; busy high for the cycles in between.
- Divide by zero: dividend=0x04D2, divisor=0 -> error=1, quotient=0xFF, remainder=0xD2, done 2 cycles after start.
- Unsigned overflow: dividend=0x1000, divisor=0x10 -> overflow=1, quotient=0x00, remainder=0x00.
- Signed: signed_mode=1, dividend=-100 (0xFF9C), divisor=7 -> quotient=0xF2 (-14), remainder=0xFE (-2).
- Signed edge: dividend=0xFF80 (-128), divisor=0xFF (-1) -> overflow=1. Same dividend with divisor=1 -> quotient=0x80, overflow=0. With SIGNED_EN=0, signed_mode=1 gives the unsigned result.
- Control: pulse start again mid-ITER with different operands -> ignored, first result is unchanged. Assert reset mid-ITER -> all outputs 0 immediately, and a new start after reset completes correctly.
